// File: rtl/cfu_mac_pkg.sv
// Shared types and control-word layout for the cfu_mac custom function unit.
package cfu_mac_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_MAC  = 3'd1,
    OP_MACU = 3'd2,
    OP_RDL  = 3'd3,
    OP_RDH  = 3'd4,
    OP_CLR  = 3'd5,
    OP_WR   = 3'd6,
    OP_RSVD = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  localparam int unsigned CtrlOpLsb  = 0;
  localparam int unsigned CtrlOpW    = 3;
  localparam int unsigned CtrlIdxLsb = 3;
  localparam int unsigned CtrlIdxW   = 5;

endpackage

// File: rtl/cfu_mac_mul_iter.sv
// Iterative unsigned multiplier: retires MUL_BPC multiplier bits per cycle,
// done_o is high in the last of the XLEN/MUL_BPC working cycles.
module cfu_mac_mul_iter #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned MUL_BPC = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [XLEN-1:0]   multiplicand_i,
  input  logic [XLEN-1:0]   multiplier_i,
  output logic              done_o,
  output logic [2*XLEN-1:0] product_o
);

  localparam int unsigned K     = XLEN / MUL_BPC;
  localparam int unsigned CntW  = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned ProdW = 2 * XLEN;

  logic             busy_q;
  logic [CntW-1:0]  cnt_q;
  logic [ProdW-1:0] mcand_q;
  logic [XLEN-1:0]  mplier_q;
  logic [ProdW-1:0] prod_q;
  logic [ProdW-1:0] partial;

  // The multiplicand is pre-shifted each cycle, so the partial product needs no
  // variable shifter.
  assign partial   = mcand_q * ProdW'(mplier_q[MUL_BPC-1:0]);
  assign done_o    = busy_q && (cnt_q == CntW'(K - 1));
  assign product_o = prod_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
    end else if (start_i) begin
      busy_q   <= 1'b1;
      cnt_q    <= '0;
      mcand_q  <= ProdW'(multiplicand_i);
      mplier_q <= multiplier_i;
      prod_q   <= '0;
    end else if (busy_q) begin
      prod_q   <= prod_q + partial;
      mcand_q  <= mcand_q << MUL_BPC;
      mplier_q <= mplier_q >> MUL_BPC;
      cnt_q    <= cnt_q + CntW'(1);
      if (done_o) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/cfu_mac.sv
// Multi-cycle multiply-accumulate CFU with a bank of double-width accumulators.
// Optional clamping of MAC/MACU sums is enabled by defining CFU_MAC_SATURATE_EN.
module cfu_mac
  import cfu_mac_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NUM_ACC = 4,
  parameter int unsigned MUL_BPC = 4,
  parameter int unsigned CTRL_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              stall_i,
  input  logic              valid_i,
  input  logic [CTRL_W-1:0] cfu_ctrl_i,
  input  logic [XLEN-1:0]   src1_i,
  input  logic [XLEN-1:0]   src2_i,
  output logic              stall_o,
  output logic [XLEN-1:0]   rslt_o
);

  localparam int unsigned AccW = 2 * XLEN;
  localparam int unsigned IdxW = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;

  state_e              state_q, state_d;
  logic [AccW-1:0]     acc_q [NUM_ACC];
  op_e                 op;
  logic [IdxW-1:0]     idx;
  logic                fire, is_mac, mac_fire;
  logic                sign_in;
  logic [XLEN-1:0]     mag1, mag2;
  logic                sign_q;
  logic [IdxW-1:0]     idx_q;
  logic                mul_done;
  logic [AccW-1:0]     product, prod_fix;
  logic [AccW-1:0]     acc_rd, acc_rd_in;
  logic [AccW:0]       usum;
  logic [AccW-1:0]     sum_wrap, sum_final;
  logic                acc_we;
  logic [IdxW-1:0]     acc_widx;
  logic [AccW-1:0]     acc_wdata;
  logic                unused_ctrl;

  assign op          = op_e'(cfu_ctrl_i[CtrlOpLsb +: CtrlOpW]);
  assign unused_ctrl = ^cfu_ctrl_i;

  if (NUM_ACC > 1) begin : g_idx
    assign idx = cfu_ctrl_i[CtrlIdxLsb +: IdxW];
  end else begin : g_idx_single
    assign idx = '0;
  end

  assign fire     = valid_i && !stall_i && (state_q == StIdle);
  assign is_mac   = (op == OP_MAC) || (op == OP_MACU);
  assign mac_fire = fire && is_mac;

  // Signed MAC multiplies magnitudes and restores the sign after the multiplier.
  assign sign_in = (op == OP_MAC) && (src1_i[XLEN-1] ^ src2_i[XLEN-1]);
  assign mag1    = ((op == OP_MAC) && src1_i[XLEN-1]) ? -src1_i : src1_i;
  assign mag2    = ((op == OP_MAC) && src2_i[XLEN-1]) ? -src2_i : src2_i;

  cfu_mac_mul_iter #(
    .XLEN    (XLEN),
    .MUL_BPC (MUL_BPC)
  ) u_mul (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .start_i        (mac_fire),
    .multiplicand_i (mag1),
    .multiplier_i   (mag2),
    .done_o         (mul_done),
    .product_o      (product)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sign_q <= 1'b0;
      idx_q  <= '0;
    end else if (mac_fire) begin
      sign_q <= sign_in;
      idx_q  <= idx;
    end
  end

  assign acc_rd_in = acc_q[idx];
  assign acc_rd    = acc_q[idx_q];
  assign prod_fix  = sign_q ? -product : product;
  assign usum      = {1'b0, acc_rd} + {1'b0, prod_fix};
  assign sum_wrap  = usum[AccW-1:0];

`ifdef CFU_MAC_SATURATE_EN
  logic macu_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      macu_q <= 1'b0;
    end else if (mac_fire) begin
      macu_q <= (op == OP_MACU);
    end
  end

  // Signed overflow: both addends share a sign that the wrapped sum lost.
  always_comb begin
    sum_final = sum_wrap;
    if (macu_q) begin
      if (usum[AccW]) begin
        sum_final = '1;
      end
    end else if ((acc_rd[AccW-1] == prod_fix[AccW-1]) &&
                 (sum_wrap[AccW-1] != acc_rd[AccW-1])) begin
      sum_final = {acc_rd[AccW-1], {(AccW-1){~acc_rd[AccW-1]}}};
    end
  end
`else
  logic unused_carry;
  assign unused_carry = usum[AccW];
  assign sum_final    = sum_wrap;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (mac_fire) state_d = StBusy;
      StBusy:  if (mul_done) state_d = StDone;
      StDone:  if (!stall_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // DONE writes back only on exit so a held result is accumulated exactly once.
  always_comb begin
    stall_o   = (state_q == StBusy) || mac_fire;
    rslt_o    = '0;
    acc_we    = 1'b0;
    acc_widx  = idx;
    acc_wdata = '0;
    if (state_q == StDone) begin
      rslt_o = sum_final[XLEN-1:0];
      if (!stall_i) begin
        acc_we    = 1'b1;
        acc_widx  = idx_q;
        acc_wdata = sum_final;
      end
    end else if (fire) begin
      case (op)
        OP_RDL: rslt_o = acc_rd_in[XLEN-1:0];
        OP_RDH: rslt_o = acc_rd_in[AccW-1:XLEN];
        OP_CLR: begin
          rslt_o = acc_rd_in[XLEN-1:0];
          acc_we = 1'b1;
        end
        OP_WR: begin
          acc_we    = 1'b1;
          acc_wdata = {src2_i, src1_i};
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '{default: '0};
    end else if (acc_we) begin
      acc_q[acc_widx] <= acc_wdata;
    end
  end

endmodule

// File: tb/tb_cfu_mac.sv
// Randomised scoreboard bench for cfu_mac against a full-width arithmetic model.
module tb_cfu_mac;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned MUL_BPC = 4;
  localparam int unsigned K       = XLEN / MUL_BPC;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_in;
  logic        valid;
  logic [7:0]  ctrl;
  logic [31:0] src1, src2;
  logic        stall;
  logic [31:0] rslt;

  always #5 clk = ~clk;

  cfu_mac #(
    .XLEN    (XLEN),
    .NUM_ACC (4),
    .MUL_BPC (MUL_BPC),
    .CTRL_W  (8)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .stall_i    (stall_in),
    .valid_i    (valid),
    .cfu_ctrl_i (ctrl),
    .src1_i     (src1),
    .src2_i     (src2),
    .stall_o    (stall),
    .rslt_o     (rslt)
  );

  typedef struct packed {
    logic [31:0] rslt;
    logic [31:0] stalls;
  } exp_t;

  exp_t        sb_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic [63:0] m_acc[4];
  int          stall_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: whole-word arithmetic on a 64-bit accumulator array.
  task automatic model(input logic [2:0] op, input int idx, input logic [31:0] a,
                       input logic [31:0] b, output logic [31:0] r);
    logic [63:0]        acc;
    logic [63:0]        p;
    logic signed [65:0] s;
    logic [65:0]        u;
    acc = m_acc[idx];
    r   = 32'h0;
    case (op)
      3'd1: begin
        p = 64'(longint'($signed(a)) * longint'($signed(b)));
        s = $signed({{2{acc[63]}}, acc}) + $signed({{2{p[63]}}, p});
        m_acc[idx] = s[63:0];
`ifdef CFU_MAC_SATURATE_EN
        if (s > 66'sh0_7FFF_FFFF_FFFF_FFFF) m_acc[idx] = 64'h7FFF_FFFF_FFFF_FFFF;
        if (s < -66'sh0_8000_0000_0000_0000) m_acc[idx] = 64'h8000_0000_0000_0000;
`endif
        r = m_acc[idx][31:0];
      end
      3'd2: begin
        p = {32'h0, a} * {32'h0, b};
        u = {2'b00, acc} + {2'b00, p};
        m_acc[idx] = u[63:0];
`ifdef CFU_MAC_SATURATE_EN
        if (u > 66'h0_FFFF_FFFF_FFFF_FFFF) m_acc[idx] = 64'hFFFF_FFFF_FFFF_FFFF;
`endif
        r = m_acc[idx][31:0];
      end
      3'd3: r = acc[31:0];
      3'd4: r = acc[63:32];
      3'd5: begin
        r = acc[31:0];
        m_acc[idx] = 64'h0;
      end
      3'd6: m_acc[idx] = {b, a};
      default: r = 32'h0;
    endcase
  endtask

  // Called at posedge+1; returns at posedge+1 after the instruction has retired.
  task automatic issue(input logic [2:0] op, input int idx, input logic [31:0] a,
                       input logic [31:0] b, input int hold);
    logic [31:0] r;
    exp_t        e;
    int          n;
    model(op, idx, a, b, r);
    e.rslt   = r;
    e.stalls = (op == 3'd1 || op == 3'd2) ? K + 1 : 0;
    sb_q.push_back(e);
    ctrl  = {5'(idx), op};
    src1  = a;
    src2  = b;
    valid = 1'b1;
    if (op == 3'd1 || op == 3'd2) begin
      @(posedge clk); #1;
      n = 0;
      while (stall && n < 4 * K) begin
        @(posedge clk); #1;
        n++;
      end
      if (stall) begin
        checks++;
        failures++;
        $display("FAIL mac_timeout: stall_o still 1 after %0d cycles, required 0", n);
        valid = 1'b0;
        return;
      end
      if (hold > 0) begin
        stall_in = 1'b1;
        for (int h = 0; h < hold; h++) begin
          @(negedge clk);
          check("done_hold_rslt", rslt, r);
          check("done_hold_stall_o", stall, 0);
        end
        @(posedge clk); #1;
        stall_in = 1'b0;
      end
    end
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  // Monitor: retires one scoreboard entry per completed instruction.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      stall_cnt = 0;
    end else if (!valid) begin
      check("idle_rslt", rslt, 0);
      check("idle_stall_o", stall, 0);
      stall_cnt = 0;
    end else if (stall_in) begin
      check("stall_i_no_stall_o", stall, 0);
    end else if (stall) begin
      stall_cnt++;
    end else begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result: got 0x%0h with no pending instruction", rslt);
      end else begin
        e = sb_q.pop_front();
        check("rslt", rslt, e.rslt);
        check("stall_cycles", stall_cnt, e.stalls);
      end
      stall_cnt = 0;
    end
  end

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [2:0] op;
    int         hold;
    rst_n    = 1'b0;
    valid    = 1'b0;
    stall_in = 1'b0;
    ctrl     = 8'h0;
    src1     = 32'h0;
    src2     = 32'h0;
    for (int i = 0; i < 4; i++) m_acc[i] = 64'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_stall_o", stall, 0);
    check("reset_rslt", rslt, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) begin
      issue(3'd3, i, $urandom, $urandom, 0);
      issue(3'd4, i, $urandom, $urandom, 0);
    end

    issue(3'd1, 1, 32'hFFFF_FFFD, 32'd7, 0);
    issue(3'd4, 1, 32'h0, 32'h0, 0);
    issue(3'd2, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    issue(3'd3, 0, 32'h0, 32'h0, 0);
    issue(3'd4, 0, 32'h0, 32'h0, 0);
    issue(3'd5, 0, 32'h0, 32'h0, 0);
    issue(3'd3, 0, 32'h0, 32'h0, 0);

    issue(3'd6, 2, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 0);
    issue(3'd1, 2, 32'd1, 32'd1, 0);
    issue(3'd4, 2, 32'h0, 32'h0, 0);
    issue(3'd3, 2, 32'h0, 32'h0, 0);

    issue(3'd1, 3, 32'd5, 32'd6, 3);
    issue(3'd3, 3, 32'h0, 32'h0, 0);

    // A stalled request in IDLE must never fire.
    ctrl     = {5'd3, 3'd6};
    src1     = 32'h1234_5678;
    src2     = 32'h9ABC_DEF0;
    valid    = 1'b1;
    stall_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    valid    = 1'b0;
    stall_in = 1'b0;
    issue(3'd3, 3, 32'h0, 32'h0, 0);
    issue(3'd4, 3, 32'h0, 32'h0, 0);

    for (int i = 0; i < 60; i++) begin
      op   = 3'($urandom_range(0, 7));
      hold = ((op == 3'd1 || op == 3'd2) && $urandom_range(0, 3) == 0) ?
             int'($urandom_range(1, 3)) : 0;
      issue(op, int'($urandom_range(0, 3)), pick(), pick(), hold);
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk); #1;
      end
    end

    // Reset during BUSY cycle 4 of a MAC aborts it.
    issue(3'd6, 1, 32'hDEAD_BEEF, 32'h0000_0001, 0);
    ctrl  = {5'd1, 3'd1};
    src1  = 32'd9;
    src2  = 32'd9;
    valid = 1'b1;
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1;
    check("busy_stall_o", stall, 1);
    rst_n = 1'b0;
    valid = 1'b0;
    #1;
    check("reset_abort_stall_o", stall, 0);
    check("reset_abort_rslt", rslt, 0);
    for (int i = 0; i < 4; i++) m_acc[i] = 64'h0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      issue(3'd3, i, 32'h0, 32'h0, 0);
      issue(3'd4, i, 32'h0, 32'h0, 0);
    end
    issue(3'd2, 1, 32'd3, 32'd4, 0);
    issue(3'd3, 1, 32'h0, 32'h0, 0);

    repeat (3) @(posedge clk);
    check("scoreboard_empty", 64'(sb_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
